// File: rtl/quad_pump_mem_arbiter_if.sv
// Request/response and memory command bundle for the quad-pump arbiter.
// master = requesters plus external memory, slave = arbiter.
interface quad_pump_mem_arbiter_if #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 16
);
    logic [3:0]             req;
    logic [3:0]             we;
    logic [3:0][ADDR_W-1:0] addr;
    logic [3:0][DATA_W-1:0] wdata;
    logic [3:0]             ack;
    logic [DATA_W-1:0]      rdata;
    logic [3:0]             rdata_valid;
    logic                   mem_en;
    logic                   mem_we;
    logic [ADDR_W-1:0]      mem_addr;
    logic [DATA_W-1:0]      mem_wdata;
    logic [DATA_W-1:0]      mem_rdata;

    modport master (
        output req, we, addr, wdata, mem_rdata,
        input  ack, rdata, rdata_valid, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  req, we, addr, wdata, mem_rdata,
        output ack, rdata, rdata_valid, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/quad_pump_mem_arbiter.sv
// Phase-slotted arbiter sharing one single-port memory among 4 requesters,
// with tagged read return and a phase-sequence monitor.
module quad_pump_mem_arbiter_lane #(
    parameter logic [1:0] LANE = 2'd0
) (
    input  logic       clk_100mhz,
    input  logic       reset,
    input  logic       req,
    input  logic       ack,
    input  logic       tail_vld,
    input  logic [1:0] tail_id,
    output logic       elig,
    output logic       rvalid
);
    // A requester just acked is still holding req for the next transfer; skip it once.
    assign elig = req & ~ack;

    always_ff @(posedge clk_100mhz) begin
        if (reset) rvalid <= 1'b0;
        else       rvalid <= tail_vld && (tail_id == LANE);
    end
endmodule

module quad_pump_mem_arbiter #(
    parameter int ADDR_W   = 18,
    parameter int DATA_W   = 16,
    parameter int RD_LAT   = 2,
    parameter int STEAL_EN = 1
) (
    input  logic                       clk_100mhz,
    input  logic                       reset,
    input  logic [1:0]                 phase,
    quad_pump_mem_arbiter_if.slave     bus,
    output logic                       phase_err
);
    localparam int NUM_REQ = 4;

    logic [NUM_REQ-1:0] elig;
    logic [NUM_REQ-1:0] rv;
    logic               grant_vld;
    logic [1:0]         grant_id;

    logic [NUM_REQ-1:0] ack_q;
    logic               mem_en_q;
    logic               mem_we_q;
    logic [ADDR_W-1:0]  mem_addr_q;
    logic [DATA_W-1:0]  mem_wdata_q;
    logic [DATA_W-1:0]  rdata_q;

    logic [RD_LAT-1:0]      vld_pipe;
    logic [RD_LAT-1:0][1:0] id_pipe;

    logic [1:0] last_phase;
    logic       armed;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
        quad_pump_mem_arbiter_lane #(.LANE(2'(i))) u_lane (
            .clk_100mhz (clk_100mhz),
            .reset      (reset),
            .req        (bus.req[i]),
            .ack        (ack_q[i]),
            .tail_vld   (vld_pipe[RD_LAT-1]),
            .tail_id    (id_pipe[RD_LAT-1]),
            .elig       (elig[i]),
            .rvalid     (rv[i])
        );
    end

    // Slot owner first, then the rest in rotating order starting after the owner.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = phase;
        if (elig[phase]) begin
            grant_vld = 1'b1;
        end else if (STEAL_EN != 0) begin
            for (int k = 1; k < NUM_REQ; k++) begin
                if (!grant_vld && elig[phase + 2'(k)]) begin
                    grant_vld = 1'b1;
                    grant_id  = phase + 2'(k);
                end
            end
        end
    end

    always_ff @(posedge clk_100mhz) begin
        if (reset) begin
            ack_q       <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            ack_q    <= '0;
            mem_en_q <= grant_vld;
            mem_we_q <= grant_vld & bus.we[grant_id];
            if (grant_vld) begin
                ack_q[grant_id] <= 1'b1;
                mem_addr_q      <= bus.addr[grant_id];
                mem_wdata_q     <= bus.wdata[grant_id];
            end
        end
    end

    // Tag rides alongside the memory latency; the tail lines up with mem_rdata.
    always_ff @(posedge clk_100mhz) begin
        if (reset) begin
            vld_pipe <= '0;
            id_pipe  <= '0;
            rdata_q  <= '0;
        end else begin
            vld_pipe[0] <= mem_en_q & ~mem_we_q;
            id_pipe[0]  <= grant_id_q();
            for (int k = 1; k < RD_LAT; k++) begin
                vld_pipe[k] <= vld_pipe[k-1];
                id_pipe[k]  <= id_pipe[k-1];
            end
            if (vld_pipe[RD_LAT-1]) rdata_q <= bus.mem_rdata;
        end
    end

    function automatic logic [1:0] grant_id_q();
        logic [1:0] id;
        id = 2'd0;
        for (int i = 0; i < NUM_REQ; i++)
            if (ack_q[i]) id = 2'(i);
        return id;
    endfunction

    always_ff @(posedge clk_100mhz) begin
        if (reset) begin
            last_phase <= 2'd0;
            armed      <= 1'b0;
            phase_err  <= 1'b0;
        end else begin
            last_phase <= phase;
            armed      <= 1'b1;
            if (armed && (phase != last_phase + 2'd1)) phase_err <= 1'b1;
        end
    end

    assign bus.ack         = ack_q;
    assign bus.mem_en      = mem_en_q;
    assign bus.mem_we      = mem_we_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wdata   = mem_wdata_q;
    assign bus.rdata       = rdata_q;
    assign bus.rdata_valid = rv;
endmodule

// File: tb/tb_quad_pump_mem_arbiter.sv
// Directed bench for quad_pump_mem_arbiter: cycle model + read-return scoreboard,
// plus a strict-TDM instance sharing the same requester inputs.
module tb_quad_pump_mem_arbiter;
    localparam int ADDR_W = 18;
    localparam int DATA_W = 16;
    localparam int RD_LAT = 2;

    logic       clk_100mhz = 1'b0;
    logic       reset      = 1'b1;
    logic [1:0] phase      = 2'd0;
    logic       phase_err;
    logic       phase_err_s;

    always #5 clk_100mhz = ~clk_100mhz;

    quad_pump_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
    quad_pump_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_s ();

    quad_pump_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .STEAL_EN(1)) u_dut (
        .clk_100mhz (clk_100mhz),
        .reset      (reset),
        .phase      (phase),
        .bus        (bus.slave),
        .phase_err  (phase_err)
    );

    quad_pump_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .STEAL_EN(0)) u_strict (
        .clk_100mhz (clk_100mhz),
        .reset      (reset),
        .phase      (phase),
        .bus        (bus_s.slave),
        .phase_err  (phase_err_s)
    );

    assign bus_s.req       = bus.req;
    assign bus_s.we        = bus.we;
    assign bus_s.addr      = bus.addr;
    assign bus_s.wdata     = bus.wdata;
    assign bus_s.mem_rdata = '0;

    // External memory: RD_LAT cycles from command cycle to data valid.
    logic [DATA_W-1:0]              tb_mem [0:1023];
    logic [RD_LAT-1:0][DATA_W-1:0]  rpipe;
    assign bus.mem_rdata = rpipe[RD_LAT-1];

    always @(posedge clk_100mhz) begin
        for (int k = RD_LAT-1; k > 0; k--) rpipe[k] <= rpipe[k-1];
        rpipe[0] <= (bus.mem_en && !bus.mem_we) ? tb_mem[bus.mem_addr[9:0]] : 16'hDEAD;
        if (bus.mem_en && bus.mem_we) tb_mem[bus.mem_addr[9:0]] <= bus.mem_wdata;
    end

    typedef struct { logic [1:0] id; logic [DATA_W-1:0] data; int due; } rd_exp_t;
    rd_exp_t rq[$];

    logic [3:0]        m_ack = '0, m_ack_s = '0;
    logic              m_en = 1'b0, m_we = 1'b0, m_perr = 1'b0, m_armed = 1'b0;
    logic [1:0]        m_id = '0, m_last = '0;
    logic [ADDR_W-1:0] m_addr = '0;
    logic [DATA_W-1:0] m_wdata = '0, m_rdata = '0;
    int cyc = 0, vec = 0, errs = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] pick(input logic [1:0] ph, input logic [3:0] rqv,
                                        input logic [3:0] ak, input bit steal);
        logic [3:0] el;
        logic [1:0] c;
        el = rqv & ~ak;
        for (int k = 0; k < 4; k++) begin
            c = ph + 2'(k);
            if (el[c] && (k == 0 || steal)) return {1'b1, c};
        end
        return 3'b000;
    endfunction

    // Check this cycle's outputs at negedge, then advance the model to the next cycle.
    task automatic cycle();
        logic [2:0] g, gs;
        logic [3:0] exp_rv;
        rd_exp_t    r;
        @(negedge clk_100mhz);
        exp_rv = '0;
        if (rq.size() > 0 && rq[0].due == cyc) begin
            r       = rq.pop_front();
            exp_rv  = 4'b0001 << r.id;
            m_rdata = r.data;
        end
        chk("ack",         32'(bus.ack),         32'(m_ack));
        chk("mem_en",      32'(bus.mem_en),      32'(m_en));
        chk("mem_we",      32'(bus.mem_we),      32'(m_we));
        chk("mem_addr",    32'(bus.mem_addr),    32'(m_addr));
        chk("mem_wdata",   32'(bus.mem_wdata),   32'(m_wdata));
        chk("rdata_valid", 32'(bus.rdata_valid), 32'(exp_rv));
        chk("rdata",       32'(bus.rdata),       32'(m_rdata));
        chk("phase_err",   32'(phase_err),       32'(m_perr));
        chk("strict_ack",  32'(bus_s.ack),       32'(m_ack_s));
        chk("strict_perr", 32'(phase_err_s),     32'(m_perr));
        if (reset) begin
            m_ack = '0; m_ack_s = '0; m_en = 1'b0; m_we = 1'b0; m_id = '0;
            m_addr = '0; m_wdata = '0; m_rdata = '0;
            m_perr = 1'b0; m_armed = 1'b0; m_last = '0;
            rq.delete();
        end else begin
            if (m_en && !m_we)
                rq.push_back('{id: m_id, data: tb_mem[m_addr[9:0]], due: cyc + RD_LAT + 1});
            g  = pick(phase, bus.req, m_ack, 1'b1);
            gs = pick(phase, bus.req, m_ack_s, 1'b0);
            m_ack   = g[2]  ? (4'b0001 << g[1:0])  : 4'b0000;
            m_ack_s = gs[2] ? (4'b0001 << gs[1:0]) : 4'b0000;
            m_en    = g[2];
            m_we    = g[2] & bus.we[g[1:0]];
            if (g[2]) begin
                m_id    = g[1:0];
                m_addr  = bus.addr[g[1:0]];
                m_wdata = bus.wdata[g[1:0]];
            end
            if (m_armed && phase != m_last + 2'd1) m_perr = 1'b1;
            m_last  = phase;
            m_armed = 1'b1;
        end
        cyc++;
        @(posedge clk_100mhz);
        #1;
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            cycle();
            phase = phase + 2'd1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        logic [1:0] p;
        int         nack;
        for (int i = 0; i < 1024; i++) tb_mem[i] = 16'h5000 ^ 16'(i * 7);
        bus.req = '0; bus.we = '0; bus.addr = '0; bus.wdata = '0;

        step(2);
        chk("reset_ack",   32'(bus.ack),         32'h0);
        chk("reset_memen", 32'(bus.mem_en),      32'h0);
        chk("reset_rv",    32'(bus.rdata_valid), 32'h0);
        reset = 1'b0;

        // 1: all four reading, owner always wins its own slot
        bus.req = 4'hF;
        for (int i = 0; i < 4; i++) bus.addr[i] = 18'h00040 + 18'(i);
        for (int i = 0; i < 12; i++) begin
            p = phase;
            cycle();
            chk("t1_ack_follows_phase", 32'(bus.ack), 32'(4'b0001 << p));
            phase = phase + 2'd1;
        end
        bus.req = '0;
        step(RD_LAT + 3);

        // 2: lone requester 2: every 2nd cycle with steal, only after phase 2 when strict
        bus.req = 4'b0100;
        bus.addr[2] = 18'h00010;
        nack = 0;
        for (int i = 0; i < 8; i++) begin
            p = phase;
            cycle();
            if (bus.ack[2]) nack++;
            chk("t2_strict_ack", 32'(bus_s.ack), (p == 2'd2) ? 32'h4 : 32'h0);
            phase = phase + 2'd1;
        end
        chk("t2_ack_count", 32'(nack), 32'd4);
        bus.req = '0;
        step(RD_LAT + 3);

        // 3: write then read back through another requester
        bus.we[0] = 1'b1; bus.addr[0] = 18'h00123; bus.wdata[0] = 16'hBEEF;
        bus.req = 4'b0001;
        for (int n = 0; n < 10 && !bus.ack[0]; n++) step(1);
        chk("t3_wr_ack", 32'(bus.ack[0]), 32'h1);
        bus.req = '0; bus.we = '0;
        bus.addr[3] = 18'h00123;
        bus.req = 4'b1000;
        for (int n = 0; n < 10 && !bus.ack[3]; n++) step(1);
        chk("t3_rd_ack", 32'(bus.ack[3]), 32'h1);
        bus.req = '0;
        step(RD_LAT);
        chk("t3_no_early_rv", 32'(bus.rdata_valid), 32'h0);
        step(1);
        chk("t3_rv",    32'(bus.rdata_valid), 32'h8);
        chk("t3_rdata", 32'(bus.rdata),       32'hBEEF);
        step(2);

        // 4: phase 0,1,2,0 breaks the sequence; grants keep flowing
        for (int n = 0; n < 4 && phase != 2'd0; n++) step(1);
        bus.req = 4'hF;
        step(3);
        chk("t4_no_err_yet", 32'(phase_err), 32'h0);
        phase = 2'd0;
        cycle();
        chk("t4_err_set", 32'(phase_err), 32'h1);
        phase = 2'd1;
        step(6);
        chk("t4_err_sticky", 32'(phase_err), 32'h1);
        bus.req = '0;
        step(RD_LAT + 3);

        // 6: owner preferred; stolen slot follows 3,0 order
        phase = 2'd0;
        cycle();
        bus.req = 4'b0011;
        phase = 2'd1;
        cycle();
        chk("t6_owner_first", 32'(bus.ack), 32'h2);
        bus.req = 4'b0001;
        phase = 2'd2;
        cycle();
        chk("t6_steal_req0", 32'(bus.ack), 32'h1);
        bus.req = '0;
        phase = 2'd3;
        step(RD_LAT + 3);

        // 5: reset one cycle after a read ack drops the in-flight return
        bus.addr[0] = 18'h00040;
        bus.req = 4'b0001;
        for (int n = 0; n < 10 && !bus.ack[0]; n++) step(1);
        chk("t5_rd_ack", 32'(bus.ack[0]), 32'h1);
        bus.req = '0;
        step(1);
        reset = 1'b1;
        step(1);
        chk("t5_ack",       32'(bus.ack),         32'h0);
        chk("t5_rv",        32'(bus.rdata_valid), 32'h0);
        chk("t5_mem_en",    32'(bus.mem_en),      32'h0);
        chk("t5_mem_we",    32'(bus.mem_we),      32'h0);
        chk("t5_phase_err", 32'(phase_err),       32'h0);
        chk("t5_rdata",     32'(bus.rdata),       32'h0);
        chk("t5_mem_addr",  32'(bus.mem_addr),    32'h0);
        chk("t5_mem_wdata", 32'(bus.mem_wdata),   32'h0);
        reset = 1'b0;
        for (int i = 0; i < RD_LAT + 2; i++) begin
            step(1);
            chk("t5_no_stale_rv", 32'(bus.rdata_valid), 32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
